// File: rtl/unidade_controle.sv
// Moore control FSM for the experiment-4 memory game: sequences one 16-position round.
// Optional ESPERA timeout enabled by defining UNIDADE_CONTROLE_TIMEOUT_EN.
module unidade_controle #(
    parameter int unsigned TIMEOUT_CICLOS = 5000,
    parameter int unsigned W_TMO          = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada_feita,
    input  logic       igual,
    input  logic       fimC,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARACAO  = 4'h1,
        ESPERA      = 4'h2,
        REGISTRA    = 4'h4,
        COMPARA     = 4'h5,
        PROXIMO     = 4'h6,
        FIM_ACERTOU = 4'hA,
        FIM_TIMEOUT = 4'hD,
        FIM_ERROU   = 4'hE
    } estado_t;

    estado_t estado_q, estado_d;
    logic    tmo_expirou_c;

    logic zeraC_q, contaC_q, zeraR_q, registraR_q;
    logic pronto_q, acertou_q, errou_q, timeout_q;
    logic zeraC_d, contaC_d, zeraR_d, registraR_d;
    logic pronto_d, acertou_d, errou_d, timeout_d;

`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;

    logic [W_TMO-1:0] tmo_q, tmo_d;

    // Counts cycles spent in ESPERA; cleared everywhere else
    always_comb begin
        tmo_d = '0;
        if (estado_q == ESPERA) begin
            tmo_d = tmo_q + W_TMO'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign tmo_expirou_c = (tmo_q == W_TMO'(TIMEOUT_CICLOS - 1));
`else
    localparam bit TMO_EN = 1'b0;

    logic cfg_unused;
    assign cfg_unused    = ^{32'(TIMEOUT_CICLOS), 32'(W_TMO)};
    assign tmo_expirou_c = 1'b0;
`endif

    // Next-state logic; outputs are decoded from the next state and registered
    always_comb begin
        estado_d    = estado_q;
        zeraC_d     = 1'b0;
        contaC_d    = 1'b0;
        zeraR_d     = 1'b0;
        registraR_d = 1'b0;
        pronto_d    = 1'b0;
        acertou_d   = 1'b0;
        errou_d     = 1'b0;
        timeout_d   = 1'b0;

        case (estado_q)
            INICIAL:     if (iniciar) estado_d = PREPARACAO;
            PREPARACAO:  estado_d = ESPERA;
            ESPERA: begin
                if (jogada_feita) begin
                    estado_d = REGISTRA;
                end else if (tmo_expirou_c) begin
                    estado_d = FIM_TIMEOUT;
                end
            end
            REGISTRA:    estado_d = COMPARA;
            COMPARA: begin
                if (!igual) begin
                    estado_d = FIM_ERROU;
                end else if (fimC) begin
                    estado_d = FIM_ACERTOU;
                end else begin
                    estado_d = PROXIMO;
                end
            end
            PROXIMO:     estado_d = ESPERA;
            FIM_ACERTOU,
            FIM_ERROU,
            FIM_TIMEOUT: if (iniciar) estado_d = PREPARACAO;
            default:     estado_d = INICIAL;
        endcase

        case (estado_d)
            PREPARACAO: begin
                zeraC_d = 1'b1;
                zeraR_d = 1'b1;
            end
            REGISTRA:    registraR_d = 1'b1;
            PROXIMO:     contaC_d    = 1'b1;
            FIM_ACERTOU: begin
                pronto_d  = 1'b1;
                acertou_d = 1'b1;
            end
            FIM_ERROU: begin
                pronto_d = 1'b1;
                errou_d  = 1'b1;
            end
            FIM_TIMEOUT: begin
                pronto_d  = 1'b1;
                errou_d   = 1'b1;
                timeout_d = TMO_EN;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q    <= INICIAL;
            zeraC_q     <= 1'b0;
            contaC_q    <= 1'b0;
            zeraR_q     <= 1'b0;
            registraR_q <= 1'b0;
            pronto_q    <= 1'b0;
            acertou_q   <= 1'b0;
            errou_q     <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            zeraC_q     <= zeraC_d;
            contaC_q    <= contaC_d;
            zeraR_q     <= zeraR_d;
            registraR_q <= registraR_d;
            pronto_q    <= pronto_d;
            acertou_q   <= acertou_d;
            errou_q     <= errou_d;
            timeout_q   <= timeout_d;
        end
    end

    assign zeraC     = zeraC_q;
    assign contaC    = contaC_q;
    assign zeraR     = zeraR_q;
    assign registraR = registraR_q;
    assign pronto    = pronto_q;
    assign acertou   = acertou_q;
    assign errou     = errou_q;
    assign timeout   = timeout_q;
    assign db_estado = estado_q;

endmodule

// File: tb/tb_unidade_controle.sv
// Scoreboarded random/directed bench for unidade_controle against a round-level reference model.
module tb_unidade_controle;

    localparam int unsigned TMO = 8;
`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0, jogada_feita = 1'b0, igual = 1'b0, fimC = 1'b0;
    logic       zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout;
    logic [3:0] db_estado;

    unidade_controle #(.TIMEOUT_CICLOS(TMO), .W_TMO(4)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada_feita(jogada_feita),
        .igual(igual), .fimC(fimC), .zeraC(zeraC), .contaC(contaC), .zeraR(zeraR),
        .registraR(registraR), .pronto(pronto), .acertou(acertou), .errou(errou),
        .timeout(timeout), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Reference model: where the round stands, how many positions passed, idle time
    typedef enum {P_IDLE, P_CLEAR, P_WAIT, P_LOAD, P_CHECK, P_STEP, P_WON, P_LOST, P_TIMED} ph_t;
    ph_t m_ph  = P_IDLE;
    int  m_pos = 0;
    int  m_idle = 0;

    logic [12:0] exp_q[$];
    int checks = 0, errors = 0;
    int n_reg = 0, n_cnt = 0;

    function automatic logic [12:0] expected();
        // {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout, db_estado}
        case (m_ph)
            P_CLEAR: return {8'b1010_0000, 4'h1};
            P_WAIT:  return {8'b0000_0000, 4'h2};
            P_LOAD:  return {8'b0001_0000, 4'h4};
            P_CHECK: return {8'b0000_0000, 4'h5};
            P_STEP:  return {8'b0100_0000, 4'h6};
            P_WON:   return {8'b0000_1100, 4'hA};
            P_LOST:  return {8'b0000_1010, 4'hE};
            P_TIMED: return {8'b0000_1011, 4'hD};
            default: return 13'h0;
        endcase
    endfunction

    task automatic model_step(input logic jog, input logic ini, input logic ig, input logic fim);
        if (reset) begin
            m_ph = P_IDLE;
        end else begin
            case (m_ph)
                P_IDLE, P_WON, P_LOST, P_TIMED: if (ini) m_ph = P_CLEAR;
                P_CLEAR: begin m_pos = 0; m_idle = 0; m_ph = P_WAIT; end
                P_WAIT: begin
                    if (jog) m_ph = P_LOAD;
                    else if (TMO_EN && m_idle == int'(TMO) - 1) m_ph = P_TIMED;
                    else m_idle++;
                end
                P_LOAD:  m_ph = P_CHECK;
                P_CHECK: m_ph = !ig ? P_LOST : (fim ? P_WON : P_STEP);
                P_STEP:  begin m_pos++; m_idle = 0; m_ph = P_WAIT; end
                default: m_ph = P_IDLE;
            endcase
        end
    endtask

    // ig: 0/1 forced comparator result, 2 = random (mostly equal)
    task automatic step(input logic jog, input logic ini, input int ig);
        jogada_feita = jog;
        iniciar      = ini;
        igual        = (ig == 2) ? ($urandom_range(31) != 0) : ig[0];
        fimC         = (m_pos == 15);
        @(posedge clock);
        model_step(jog, ini, igual, fimC);
        exp_q.push_back(expected());
        #1;
    endtask

    task automatic play(input int ig, input logic jog_in_step);
        step(1'b1, 1'b0, 2);
        step(1'b0, 1'b0, 2);
        step(1'b0, 1'b0, ig);
        step(jog_in_step, 1'b0, 2);
        step(1'b0, 1'b0, 2);
    endtask

    task automatic check_val(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Monitor: every cycle the DUT presents a new output vector
    always @(negedge clock) begin
        logic [12:0] act, e;
        act = {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout, db_estado};
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL outputs @%0t: got %b_%h, required %b_%h",
                         $time, act[12:4], act[3:0], e[12:4], e[3:0]);
            end
        end
        if (registraR) n_reg++;
        if (contaC) n_cnt++;
    end

    initial begin
        logic prev_jog;
        #1;
        check_val("reset_outputs", int'({zeraC, contaC, zeraR, registraR, pronto, acertou,
                                         errou, timeout, db_estado}), 0);
        step(1'b0, 1'b0, 2);
        step(1'b1, 1'b0, 2);
        reset = 1'b0;

        // jogada_feita in INICIAL ignored, then a full correct round
        step(1'b1, 1'b0, 2);
        step(1'b0, 1'b0, 2);
        step(1'b0, 1'b1, 2);
        step(1'b0, 1'b0, 2);
        n_reg = 0; n_cnt = 0;
        for (int i = 0; i < 16; i++) play(1, 1'b1);
        step(1'b1, 1'b0, 2);
        step(1'b0, 1'b0, 2);
        check_val("hit_round_registraR", n_reg, 16);
        check_val("hit_round_contaC", n_cnt, 15);

        // miss on the third play
        step(1'b0, 1'b1, 2);
        step(1'b0, 1'b0, 2);
        n_reg = 0; n_cnt = 0;
        play(1, 1'b0);
        play(1, 1'b0);
        play(0, 1'b0);
        check_val("miss_round_registraR", n_reg, 3);
        check_val("miss_round_contaC", n_cnt, 2);

        // new round, reset while in COMPARA
        step(1'b0, 1'b1, 2);
        step(1'b0, 1'b0, 2);
        step(1'b1, 1'b0, 2);
        step(1'b0, 1'b0, 2);
        #1 reset = 1'b1;
        #1;
        check_val("async_reset_db_estado", int'(db_estado), 0);
        check_val("async_reset_outputs", int'({zeraC, contaC, zeraR, registraR, pronto,
                                               acertou, errou, timeout}), 0);
        exp_q.delete();
        m_ph = P_IDLE;
        @(posedge clock); #1;
        step(1'b1, 1'b1, 2);
        reset = 1'b0;
        step(1'b0, 1'b0, 2);

        // held iniciar enters PREPARACAO once; play lands on the last allowed idle cycle
        step(1'b0, 1'b1, 2);
        step(1'b0, 1'b1, 2);
        iniciar = 1'b0;
        for (int i = 0; i < int'(TMO) - 1; i++) step(1'b0, 1'b0, 2);
        play(1, 1'b0);

        // long idle in ESPERA
        for (int i = 0; i < 10000; i++) step(1'b0, 1'b0, 2);
        check_val("idle_timeout_out", int'(timeout), TMO_EN ? 1 : 0);
        check_val("idle_db_estado", int'(db_estado), TMO_EN ? 'hD : 'h2);

        // randomized rounds
        step(1'b0, 1'b1, 2);
        prev_jog = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            logic j;
            j = !prev_jog && ($urandom_range(2) == 0);
            step(j, $urandom_range(24) == 0, 2);
            prev_jog = j;
        end
        step(1'b0, 1'b0, 2);
        @(negedge clock); #1;
        check_val("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
